// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch/jump flushes, memory-wait freeze with timeout.
// Latency: all stage controls are combinational from state and inputs; state updates on the next edge.
// Backpressure: a pending memory access freezes the whole pipe until MEM_Ready or the timeout expires.
// Optional feature: define HAZARD_PERF_EN to build the StallCycles/FlushCount performance counters.
module hazard_ctrl #(
  parameter logic [7:0] MEM_TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IDEX_MemRead,
  input  logic [4:0]  IDEX_Rt,
  input  logic [4:0]  IFID_Rs,
  input  logic [4:0]  IFID_Rt,
  input  logic        ID_Jump,
  input  logic        EX_BranchTaken,
  input  logic        MEM_Access,
  input  logic        MEM_Ready,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        IDEXWrite,
  output logic        IFIDFlush,
  output logic        IDEXFlush,
  output logic        Freeze,
  output logic        MemTimeout,
  output logic [15:0] StallCycles,
  output logic [15:0] FlushCount
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    TIMEOUT = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic       br_pend, br_pend_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;

  logic ld_use;
  logic frozen;
  logic taken;

  assign ld_use = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
                  ((IDEX_Rt == IFID_Rs) || (IDEX_Rt == IFID_Rt));

  // TIMEOUT freezes unconditionally; otherwise freeze only while an access is outstanding.
  assign frozen = (state == TIMEOUT) || (MEM_Access && !MEM_Ready);

  // A branch that resolved while frozen is remembered in br_pend and flushed on release.
  assign taken = EX_BranchTaken || br_pend;

  // State, pending-branch flag and wait counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      br_pend  <= 1'b0;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      br_pend  <= br_pend_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Next-state logic. wait_cnt holds the number of frozen cycles completed for this access,
  // so the cycle in which it reaches MEM_TIMEOUT-1 is the last frozen cycle allowed.
  always_comb begin
    state_nxt    = state;
    br_pend_nxt  = br_pend;
    wait_cnt_nxt = wait_cnt;
    case (state)
      RUN: begin
        if (frozen) begin
          state_nxt    = (MEM_TIMEOUT <= 8'd1) ? TIMEOUT : MEMWAIT;
          wait_cnt_nxt = 8'd1;
          br_pend_nxt  = EX_BranchTaken;
        end
      end
      MEMWAIT: begin
        br_pend_nxt = br_pend || EX_BranchTaken;
        if (MEM_Ready) begin
          state_nxt    = RUN;
          br_pend_nxt  = 1'b0;
          wait_cnt_nxt = 8'd0;
        end else if (frozen) begin
          wait_cnt_nxt = wait_cnt + 8'd1;
          if (wait_cnt >= (MEM_TIMEOUT - 8'd1)) begin
            state_nxt = TIMEOUT;
          end
        end
      end
      TIMEOUT: begin
        state_nxt = TIMEOUT;
      end
      default: begin
        state_nxt    = RUN;
        br_pend_nxt  = 1'b0;
        wait_cnt_nxt = 8'd0;
      end
    endcase
  end

  // Stage control outputs: reset override, then freeze, then taken > load-use > jump priority.
  always_comb begin
    PCWrite    = 1'b1;
    IFIDWrite  = 1'b1;
    IDEXWrite  = 1'b1;
    IFIDFlush  = 1'b0;
    IDEXFlush  = 1'b0;
    Freeze     = 1'b0;
    MemTimeout = 1'b0;
    if (reset) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      IDEXWrite = 1'b0;
      IFIDFlush = 1'b1;
      IDEXFlush = 1'b1;
    end else begin
      MemTimeout = (state == TIMEOUT);
      if (frozen) begin
        Freeze    = 1'b1;
        PCWrite   = 1'b0;
        IFIDWrite = 1'b0;
        IDEXWrite = 1'b0;
      end else if (taken) begin
        IFIDFlush = 1'b1;
        IDEXFlush = 1'b1;
      end else if (ld_use) begin
        PCWrite   = 1'b0;
        IFIDWrite = 1'b0;
        IDEXFlush = 1'b1;
      end else if (ID_Jump) begin
        IFIDFlush = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic [15:0] stall_q;
  logic [15:0] flush_q;

  // Saturating counters of stalled cycles (PC held) and ID/EX flush cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= 16'd0;
      flush_q <= 16'd0;
    end else begin
      if (!PCWrite && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
      if (IDEXFlush && (flush_q != 16'hFFFF)) flush_q <= flush_q + 16'd1;
    end
  end

  assign StallCycles = stall_q;
  assign FlushCount  = flush_q;
`else
  assign StallCycles = 16'd0;
  assign FlushCount  = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: expected output vectors are queued as stimulus is driven
// and popped for comparison at the following falling edge.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        IDEX_MemRead = 1'b0;
  logic [4:0]  IDEX_Rt = 5'd0;
  logic [4:0]  IFID_Rs = 5'd0;
  logic [4:0]  IFID_Rt = 5'd0;
  logic        ID_Jump = 1'b0;
  logic        EX_BranchTaken = 1'b0;
  logic        MEM_Access = 1'b0;
  logic        MEM_Ready = 1'b0;
  logic        PCWrite, IFIDWrite, IDEXWrite, IFIDFlush, IDEXFlush, Freeze, MemTimeout;
  logic [15:0] StallCycles, FlushCount;

  int errors = 0;
  int checks = 0;
  logic [6:0] sb [$];

  // Expected output vectors {PCWrite,IFIDWrite,IDEXWrite,IFIDFlush,IDEXFlush,Freeze,MemTimeout}
  localparam logic [6:0] O_RUN = 7'b1110000;
  localparam logic [6:0] O_LDU = 7'b0010100;
  localparam logic [6:0] O_TKN = 7'b1111100;
  localparam logic [6:0] O_JMP = 7'b1111000;
  localparam logic [6:0] O_FRZ = 7'b0000010;
  localparam logic [6:0] O_TMO = 7'b0000011;
  localparam logic [6:0] O_RST = 7'b0001100;

  hazard_ctrl #(.MEM_TIMEOUT(8'd4)) dut (
    .clk(clk), .reset(reset),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt),
    .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt),
    .ID_Jump(ID_Jump), .EX_BranchTaken(EX_BranchTaken),
    .MEM_Access(MEM_Access), .MEM_Ready(MEM_Ready),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEXWrite(IDEXWrite),
    .IFIDFlush(IFIDFlush), .IDEXFlush(IDEXFlush), .Freeze(Freeze),
    .MemTimeout(MemTimeout), .StallCycles(StallCycles), .FlushCount(FlushCount)
  );

  always #5 clk = ~clk;

  // Stimulus word: {reset, MemRead, IDEX_Rt, IFID_Rs, IFID_Rt, Jump, BranchTaken, Access, Ready}
  function automatic logic [20:0] mk(input logic rst, input logic mr, input logic [4:0] rt,
                                     input logic [4:0] rs, input logic [4:0] irt, input logic j,
                                     input logic br, input logic acc, input logic rdy);
    return {rst, mr, rt, rs, irt, j, br, acc, rdy};
  endfunction

  localparam logic [20:0] S_IDLE = 21'd0;
  localparam logic [20:0] S_RST  = 21'h100000;
  localparam logic [20:0] S_ACC  = 21'h000002;
  localparam logic [20:0] S_RDY  = 21'h000003;
  localparam logic [20:0] S_BR   = 21'h000004;

  task automatic apply(input logic [20:0] s);
    {reset, IDEX_MemRead, IDEX_Rt, IFID_Rs, IFID_Rt, ID_Jump, EX_BranchTaken, MEM_Access, MEM_Ready} = s;
  endtask

  function automatic logic [6:0] outv();
    return {PCWrite, IFIDWrite, IDEXWrite, IFIDFlush, IDEXFlush, Freeze, MemTimeout};
  endfunction

  task automatic test_reset();
    logic [20:0] st [0:1];
    logic [6:0]  ex [0:1];
    logic [6:0]  got, exp;
    st = '{S_RST, S_IDLE};
    ex = '{O_RST, O_RUN};
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1; apply(st[i]); sb.push_back(ex[i]);
      @(negedge clk); got = outv(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL reset[%0d]: got %b expected %b", i, got, exp); end
    end
    checks++;
    if (StallCycles !== 16'd0 || FlushCount !== 16'd0) begin
      errors++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", StallCycles, FlushCount);
    end
  endtask

  task automatic test_load_use();
    logic [20:0] st [0:4];
    logic [6:0]  ex [0:4];
    logic [6:0]  got, exp;
    st = '{mk(0,1,5'd5,5'd5,5'd0,0,0,0,0), S_IDLE, mk(0,1,5'd7,5'd1,5'd7,0,0,0,0),
           mk(0,1,5'd9,5'd1,5'd2,0,0,0,0), mk(0,0,5'd5,5'd5,5'd5,0,0,0,0)};
    ex = '{O_LDU, O_RUN, O_LDU, O_RUN, O_RUN};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1; apply(st[i]); sb.push_back(ex[i]);
      @(negedge clk); got = outv(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL load_use[%0d]: got %b expected %b", i, got, exp); end
    end
  endtask

  task automatic test_rt_zero();
    logic [6:0] got, exp;
    @(posedge clk); #1; apply(mk(0,1,5'd0,5'd0,5'd0,0,0,0,0)); sb.push_back(O_RUN);
    @(negedge clk); got = outv(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL rt_zero: got %b expected %b", got, exp); end
  endtask

  task automatic test_priority();
    logic [20:0] st [0:4];
    logic [6:0]  ex [0:4];
    logic [6:0]  got, exp;
    st = '{mk(0,1,5'd3,5'd3,5'd0,1,1,0,0), mk(0,1,5'd3,5'd3,5'd0,1,0,0,0),
           mk(0,0,5'd0,5'd0,5'd0,1,0,0,0), S_BR, S_IDLE};
    ex = '{O_TKN, O_LDU, O_JMP, O_TKN, O_RUN};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1; apply(st[i]); sb.push_back(ex[i]);
      @(negedge clk); got = outv(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL priority[%0d]: got %b expected %b", i, got, exp); end
    end
  endtask

  task automatic test_mem_wait_branch();
    logic [20:0] st [0:4];
    logic [6:0]  ex [0:4];
    logic [6:0]  got, exp;
    // Load-use and jump in a frozen cycle must not leak through the freeze.
    st = '{S_ACC, S_ACC | S_BR, mk(0,1,5'd4,5'd4,5'd0,1,0,1,0), S_RDY, S_IDLE};
    ex = '{O_FRZ, O_FRZ, O_FRZ, O_TKN, O_RUN};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1; apply(st[i]); sb.push_back(ex[i]);
      @(negedge clk); got = outv(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL mem_wait_branch[%0d]: got %b expected %b", i, got, exp); end
    end
  endtask

  task automatic test_ready_same_cycle();
    logic [20:0] st [0:4];
    logic [6:0]  ex [0:4];
    logic [6:0]  got, exp;
    // Zero-wait access, then a one-cycle wait released while a load-use is present.
    st = '{S_RDY, S_IDLE, S_ACC, mk(0,1,5'd6,5'd0,5'd6,0,0,1,1), S_IDLE};
    ex = '{O_RUN, O_RUN, O_FRZ, O_LDU, O_RUN};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1; apply(st[i]); sb.push_back(ex[i]);
      @(negedge clk); got = outv(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL ready_same_cycle[%0d]: got %b expected %b", i, got, exp); end
    end
  endtask

  task automatic test_timeout();
    logic [20:0] st [0:13];
    logic [6:0]  ex [0:13];
    logic [6:0]  got, exp;
    st = '{S_ACC, S_ACC, S_ACC, S_ACC, S_ACC, S_IDLE, S_RDY, S_RST, S_IDLE,
           S_ACC, S_ACC | S_BR, S_RST, S_IDLE, S_IDLE};
    ex = '{O_FRZ, O_FRZ, O_FRZ, O_FRZ, O_TMO, O_TMO, O_TMO, O_RST, O_RUN,
           O_FRZ, O_FRZ, O_RST, O_RUN, O_RUN};
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1; apply(st[i]); sb.push_back(ex[i]);
      @(negedge clk); got = outv(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL timeout[%0d]: got %b expected %b", i, got, exp); end
    end
  endtask

  task automatic test_perf();
    logic [20:0] st [0:6];
    logic [6:0]  ex [0:6];
    logic [6:0]  got, exp;
    logic [15:0] exp_stall, exp_flush;
    st = '{S_RST, mk(0,1,5'd2,5'd2,5'd0,0,0,0,0), S_IDLE, mk(0,1,5'd8,5'd0,5'd8,0,0,0,0),
           S_IDLE, S_BR, S_IDLE};
    ex = '{O_RST, O_LDU, O_RUN, O_LDU, O_RUN, O_TKN, O_RUN};
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1; apply(st[i]); sb.push_back(ex[i]);
      @(negedge clk); got = outv(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL perf[%0d]: got %b expected %b", i, got, exp); end
    end
`ifdef HAZARD_PERF_EN
    exp_stall = 16'd2;
    exp_flush = 16'd3;
`else
    exp_stall = 16'd0;
    exp_flush = 16'd0;
`endif
    checks++;
    if (StallCycles !== exp_stall) begin
      errors++; $display("FAIL perf_stall: got %0d expected %0d", StallCycles, exp_stall);
    end
    checks++;
    if (FlushCount !== exp_flush) begin
      errors++; $display("FAIL perf_flush: got %0d expected %0d", FlushCount, exp_flush);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_rt_zero();
    test_priority();
    test_mem_wait_branch();
    test_ready_same_cycle();
    test_timeout();
    test_perf();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
